// File: rtl/coco_audio_pkg.sv
// Shared constants, sample type and helpers for the CoCo audio mixer.
package coco_audio_pkg;

    localparam int unsigned MIDPOINT           = 48;
    localparam int unsigned DCBLOCK_SHIFT      = 12;
    localparam int unsigned DEFAULT_TICK_DIV   = 4;
    localparam int unsigned DEFAULT_SAMPLE_DIV = 1193;

    typedef logic signed [15:0] pcm_t;

    // Clamp a wide signed value into the 16-bit PCM range.
    function automatic pcm_t sat_pcm(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7fff;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return pcm_t'(v);
        end
    endfunction

endpackage

// File: rtl/audio_onepole_lpf.sv
// Tick-enabled one-pole IIR. Track=0: acc += x - (acc >>> Shift);
// Track=1: acc += (x - acc) >>> Shift (slow follower used as a DC tracker).
module audio_onepole_lpf #(
    parameter int unsigned Shift = 5,
    parameter int unsigned Width = 9 + Shift,
    parameter bit          Track = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    tick_i,
    input  logic signed [Width-1:0] x_i,
    output logic signed [Width-1:0] acc_o
);

    logic signed [Width-1:0] acc_q, acc_d;

    if (Track) begin : g_track
        // One extra bit keeps x - acc from wrapping before the shift.
        always_comb begin
            acc_d = acc_q + Width'($signed({x_i[Width-1], x_i} - {acc_q[Width-1], acc_q})
                                   >>> Shift);
        end
    end else begin : g_leaky
        always_comb begin
            acc_d = acc_q + x_i - (acc_q >>> Shift);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            acc_q <= '0;
        end else if (tick_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/coco_audio_mixer.sv
// Mixes DAC and 1-bit sound, low-passes and decimates to signed 16-bit PCM.
// Optional DC blocker enabled by defining COCO_AUDIO_DCBLOCK_EN.
module coco_audio_mixer
    import coco_audio_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int unsigned SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int unsigned LPF_SHIFT  = 5,
    parameter int unsigned BIT_LEVEL  = 32
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [5:0]  dac_data_i,
    input  logic        snden_i,
    input  logic        sndout_i,
    input  logic        mute_i,
    output logic [15:0] pcm_o,
    output logic        pcm_stb_o
);

    localparam int unsigned AccW    = 9 + LPF_SHIFT;
    localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SampleW = $clog2(SAMPLE_DIV);

    logic [5:0] dac_q;
    logic       snden_q, sndout_q, mute_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            dac_q    <= '0;
            snden_q  <= 1'b0;
            sndout_q <= 1'b0;
            mute_q   <= 1'b0;
        end else begin
            dac_q    <= dac_data_i;
            snden_q  <= snden_i;
            sndout_q <= sndout_i;
            mute_q   <= mute_i;
        end
    end

    logic [6:0]            mix_x;
    logic signed [7:0]     mix_xs;
    logic signed [AccW-1:0] lpf_x;

    always_comb begin
        mix_x  = (snden_q ? {1'b0, dac_q} : 7'd0) + (sndout_q ? 7'(BIT_LEVEL) : 7'd0);
        mix_xs = $signed({1'b0, mix_x}) - $signed(8'(MIDPOINT));
        lpf_x  = AccW'(mix_xs);
    end

    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SampleW-1:0] smp_cnt_q, smp_cnt_d;
    logic               tick, sample;

    always_comb begin
        tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
        sample     = (smp_cnt_q == SampleW'(SAMPLE_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        smp_cnt_d  = sample ? '0 : smp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            tick_cnt_q <= '0;
            smp_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
        end
    end

    logic signed [AccW-1:0] acc;

    audio_onepole_lpf #(
        .Shift (LPF_SHIFT),
        .Width (AccW),
        .Track (1'b0)
    ) u_lpf (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .tick_i   (tick),
        .x_i      (lpf_x),
        .acc_o    (acc)
    );

    pcm_t pcm_y;

`ifdef COCO_AUDIO_DCBLOCK_EN
    logic signed [AccW-1:0] dc;

    audio_onepole_lpf #(
        .Shift (DCBLOCK_SHIFT),
        .Width (AccW),
        .Track (1'b1)
    ) u_dc (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .tick_i   (tick),
        .x_i      (acc),
        .acc_o    (dc)
    );

    always_comb begin
        pcm_y = sat_pcm((32'(acc) - 32'(dc)) <<< (8 - LPF_SHIFT));
    end
`else
    always_comb begin
        pcm_y = pcm_t'(32'(acc) <<< (8 - LPF_SHIFT));
    end
`endif

    pcm_t pcm_q, pcm_d;
    logic stb_q, stb_d;

    // pcm_y is derived from acc before this edge's filter update.
    always_comb begin
        pcm_d = pcm_q;
        stb_d = 1'b0;
        if (sample) begin
            pcm_d = mute_q ? '0 : pcm_y;
            stb_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pcm_q <= '0;
            stb_q <= 1'b0;
        end else begin
            pcm_q <= pcm_d;
            stb_q <= stb_d;
        end
    end

    assign pcm_o     = pcm_q;
    assign pcm_stb_o = stb_q;

endmodule
